// File: rtl/psum_accum_drain.sv
// Per-lane signed psum accumulator bank with a shadow snapshot that is drained
// serially over valid/ready while the live bank keeps accumulating.
module psum_accum_drain #(
    parameter int NUM_CH = 16,
    parameter int PSUM_W = 18,
    parameter int ACC_W  = 32,
    parameter bit SAT_EN = 1'b1,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_en,
    input  logic                     acc_clear,
    input  logic [NUM_CH*PSUM_W-1:0] psum_in,
    input  logic                     drain_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy,
    output logic                     drain_done,
    output logic                     overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Returns {overflow, next value}; the sum is formed one bit wider than the accumulator.
    function automatic logic [ACC_W:0] lane_next(
        input logic [ACC_W-1:0]  acc,
        input logic [PSUM_W-1:0] psum,
        input logic              clr,
        input logic              en
    );
        logic [ACC_W:0]   base_v;
        logic [ACC_W:0]   add_v;
        logic [ACC_W:0]   sum_v;
        logic             ovf_v;
        logic [ACC_W-1:0] res_v;
        base_v = clr ? {(ACC_W+1){1'b0}} : {acc[ACC_W-1], acc};
        add_v  = en ? {{(ACC_W+1-PSUM_W){psum[PSUM_W-1]}}, psum} : {(ACC_W+1){1'b0}};
        sum_v  = base_v + add_v;
        ovf_v  = sum_v[ACC_W] ^ sum_v[ACC_W-1];
        if (ovf_v && SAT_EN) begin
            res_v = sum_v[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            res_v = sum_v[ACC_W-1:0];
        end
        return {ovf_v, res_v};
    endfunction

    logic [1:0]       state_r;
    logic [CH_W-1:0]  ptr_r;
    logic [ACC_W-1:0] acc_r    [NUM_CH];
    logic [ACC_W-1:0] shadow_r [NUM_CH];
    logic [ACC_W-1:0] nxt_s    [NUM_CH];
    logic [NUM_CH-1:0] lane_ovf_s;
    logic             drain_go_s;
    logic             hs_s;
    logic             last_s;
    logic [CH_W-1:0]  ptr_inc_s;

    // Next value and overflow flag for every lane.
    always_comb begin
        lane_ovf_s = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            {lane_ovf_s[k], nxt_s[k]} = lane_next(acc_r[k], psum_in[k*PSUM_W +: PSUM_W],
                                                  acc_clear, acc_en);
        end
    end

    // Drain control decode.
    always_comb begin
        drain_go_s = (state_r == ST_IDLE) && drain_start;
        hs_s       = (state_r == ST_DRAIN) && out_valid && out_ready;
        last_s     = (ptr_r == CH_W'(NUM_CH - 1));
        ptr_inc_s  = ptr_r + CH_W'(1'b1);
    end

    // Live accumulator bank; a snapshot cycle hands its sum to the shadow bank instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_r[k] <= {ACC_W{1'b0}};
            end
            overflow <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_r[k] <= drain_go_s ? {ACC_W{1'b0}} : nxt_s[k];
            end
            overflow <= (acc_clear ? 1'b0 : overflow) | (|lane_ovf_s);
        end
    end

    // Shadow bank, written only when a drain is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_r[k] <= {ACC_W{1'b0}};
            end
        end else if (drain_go_s) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_r[k] <= nxt_s[k];
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_r[k] <= shadow_r[k];
            end
        end
    end

    // Drain FSM with registered output word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {CH_W{1'b0}};
            out_valid  <= 1'b0;
            out_data   <= {ACC_W{1'b0}};
            out_ch     <= {CH_W{1'b0}};
            busy       <= 1'b0;
            drain_done <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    drain_done <= 1'b0;
                    if (drain_go_s) begin
                        state_r   <= ST_DRAIN;
                        ptr_r     <= {CH_W{1'b0}};
                        out_valid <= 1'b1;
                        // Shadow is being written this edge, so take lane 0 straight from nxt.
                        out_data  <= nxt_s[0];
                        out_ch    <= {CH_W{1'b0}};
                        busy      <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (hs_s) begin
                        if (last_s) begin
                            out_valid  <= 1'b0;
                            drain_done <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            ptr_r    <= ptr_inc_s;
                            out_ch   <= ptr_inc_s;
                            out_data <= shadow_r[ptr_inc_s];
                        end
                    end
                end
                ST_DONE: begin
                    drain_done <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    out_valid  <= 1'b0;
                    busy       <= 1'b0;
                    drain_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_drain.sv
// Randomised and directed bench for psum_accum_drain: default build against a
// behavioural model, plus a small wrapping build with directed checks.
module tb_psum_accum_drain;

    localparam int NCH = 16;
    localparam int PW  = 18;
    localparam int AW  = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, acc_en, acc_clear, drain_start, out_ready;
    logic [NCH*PW-1:0] psum_in;
    logic              out_valid, busy, drain_done, overflow;
    logic [AW-1:0]     out_data;
    logic [3:0]        out_ch;

    logic        s_rst, s_acc_en, s_acc_clear, s_drain_start, s_out_ready;
    logic [31:0] s_psum;
    logic        s_out_valid, s_busy, s_drain_done, s_overflow;
    logic [11:0] s_out_data;
    logic [1:0]  s_out_ch;

    psum_accum_drain dut (
        .clk(clk), .rst(rst), .acc_en(acc_en), .acc_clear(acc_clear), .psum_in(psum_in),
        .drain_start(drain_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .busy(busy), .drain_done(drain_done),
        .overflow(overflow)
    );

    psum_accum_drain #(.NUM_CH(4), .PSUM_W(8), .ACC_W(12), .SAT_EN(1'b0)) dut_small (
        .clk(clk), .rst(s_rst), .acc_en(s_acc_en), .acc_clear(s_acc_clear), .psum_in(s_psum),
        .drain_start(s_drain_start), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_ch(s_out_ch), .busy(s_busy), .drain_done(s_drain_done),
        .overflow(s_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int done_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: live lanes as plain integers, pending drain words as a queue.
    longint acc_m [NCH];
    longint snap_q[$];
    int     ch_m;
    bit     act_m, done_m, ovf_m;

    function automatic longint lane_psum(input int k);
        return longint'($signed(psum_in[k*PW +: PW]));
    endfunction

    task automatic model_step();
        longint nv [NCH];
        longint v;
        bit any_ovf;
        bit n_done;
        bit n_act;
        if (!rst) begin
            for (int k = 0; k < NCH; k++) acc_m[k] = 0;
            snap_q.delete();
            ch_m = 0; act_m = 1'b0; done_m = 1'b0; ovf_m = 1'b0;
            return;
        end
        any_ovf = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            v = (acc_clear ? 64'sd0 : acc_m[k]) + (acc_en ? lane_psum(k) : 64'sd0);
            if (v > MAXV) begin any_ovf = 1'b1; v = MAXV; end
            else if (v < MINV) begin any_ovf = 1'b1; v = MINV; end
            nv[k] = v;
        end
        ovf_m  = (acc_clear ? 1'b0 : ovf_m) | any_ovf;
        n_done = 1'b0;
        n_act  = done_m ? 1'b0 : act_m;
        if (!act_m && drain_start) begin
            for (int k = 0; k < NCH; k++) begin
                snap_q.push_back(nv[k]);
                acc_m[k] = 0;
            end
            ch_m  = 0;
            n_act = 1'b1;
        end else begin
            for (int k = 0; k < NCH; k++) acc_m[k] = nv[k];
            if (snap_q.size() > 0 && out_ready) begin
                void'(snap_q.pop_front());
                ch_m++;
                if (snap_q.size() == 0) n_done = 1'b1;
            end
        end
        done_m = n_done;
        act_m  = n_act;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) begin
            check("valid", longint'(out_valid), longint'(snap_q.size() > 0));
            check("busy", longint'(busy), longint'(act_m));
            check("drain_done", longint'(drain_done), longint'(done_m));
            check("overflow", longint'(overflow), longint'(ovf_m));
            if (snap_q.size() > 0) begin
                check("data", longint'($signed(out_data)), snap_q[0]);
                check("ch", longint'(out_ch), longint'(ch_m));
            end
        end
        if (out_valid && out_ready) hs_cnt++;
        if (drain_done) done_cnt++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < NCH; k++) psum_in[k*PW +: PW] = PW'(v);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < NCH; k++) psum_in[k*PW +: PW] = PW'(k + 1);
    endtask

    task automatic idle_inputs();
        acc_en = 1'b0; acc_clear = 1'b0; drain_start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; out_ready = 1'b0; psum_in = '0;
        idle_inputs();
        s_rst = 1'b0; s_acc_en = 1'b0; s_acc_clear = 1'b0; s_drain_start = 1'b0;
        s_out_ready = 1'b0; s_psum = 32'd0;

        // Reset state
        run(2);
        chk_en = 1'b1;
        check("rst_valid", longint'(out_valid), 0);
        check("rst_data", longint'(out_data), 0);
        check("rst_ch", longint'(out_ch), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_ovf", longint'(overflow), 0);
        rst = 1'b1;

        // Basic sum: four cycles of ramp then a full-rate drain
        acc_clear = 1'b1; cycle(); acc_clear = 1'b0;
        set_ramp(); acc_en = 1'b1; run(4); acc_en = 1'b0;
        hs_cnt = 0; done_cnt = 0;
        out_ready = 1'b1; drain_start = 1'b1; cycle(); drain_start = 1'b0;
        check("basic_w0", longint'($signed(out_data)), 4);
        run(20);
        check("basic_words", hs_cnt, 16);
        check("basic_done_pulses", done_cnt, 1);
        check("basic_busy_after", longint'(busy), 0);

        // Backpressure with a 1,0,0,1 ready pattern
        set_ramp(); acc_en = 1'b1; run(3); acc_en = 1'b0;
        hs_cnt = 0;
        drain_start = 1'b1; cycle(); drain_start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            cycle();
        end
        check("bp_words", hs_cnt, 16);

        // Overlap: live accumulation during the drain, then a second drain
        out_ready = 1'b1; acc_clear = 1'b1; cycle(); acc_clear = 1'b0;
        drain_start = 1'b1; cycle(); drain_start = 1'b0;
        set_all(1); acc_en = 1'b1; run(20);
        drain_start = 1'b1; cycle(); drain_start = 1'b0; acc_en = 1'b0;
        check("overlap_w0", longint'($signed(out_data)), 21);
        run(20);

        // Simultaneous: drain_start with acc_en, and drain_start ignored mid-drain
        set_all(5); acc_clear = 1'b1; acc_en = 1'b1; cycle(); acc_clear = 1'b0;
        set_all(3); drain_start = 1'b1; cycle();
        check("simul_snap", longint'($signed(out_data)), 8);
        acc_en = 1'b0; hs_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            drain_start = (i % 3 == 0);
            cycle();
        end
        drain_start = 1'b0; run(10);
        check("simul_words", hs_cnt, 16);
        drain_start = 1'b1; cycle(); drain_start = 1'b0;
        check("simul_live_zero", longint'($signed(out_data)), 0);
        run(20);

        // Saturation, positive then negative
        acc_clear = 1'b1; cycle(); acc_clear = 1'b0;
        set_all(0); psum_in[PW-1:0] = 18'sd131071; acc_en = 1'b1;
        run(16500); acc_en = 1'b0;
        check("sat_pos_ovf", longint'(overflow), 1);
        drain_start = 1'b1; cycle(); drain_start = 1'b0;
        check("sat_pos_w0", longint'($signed(out_data)), MAXV);
        run(20);
        acc_clear = 1'b1; cycle(); acc_clear = 1'b0;
        check("sat_clear_ovf", longint'(overflow), 0);
        psum_in[PW-1:0] = -18'sd131072; acc_en = 1'b1;
        run(16500); acc_en = 1'b0;
        drain_start = 1'b1; cycle(); drain_start = 1'b0;
        check("sat_neg_w0", longint'($signed(out_data)), MINV);
        run(20);
        acc_clear = 1'b1; cycle(); acc_clear = 1'b0;

        // Reset mid-drain
        set_ramp(); acc_en = 1'b1; run(2); acc_en = 1'b0;
        drain_start = 1'b1; cycle(); drain_start = 1'b0;
        run(7);
        check("mid_ch7", longint'(out_ch), 7);
        rst = 1'b0; cycle(); rst = 1'b1;
        check("mid_valid", longint'(out_valid), 0);
        check("mid_busy", longint'(busy), 0);
        done_cnt = 0; run(20);
        check("mid_no_done", done_cnt, 0);
        drain_start = 1'b1; cycle(); drain_start = 1'b0;
        check("mid_acc_zero", longint'($signed(out_data)), 0);
        run(20);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            acc_en      = ($urandom_range(0, 9) < 7);
            acc_clear   = ($urandom_range(0, 19) == 0);
            drain_start = ($urandom_range(0, 9) == 0);
            out_ready   = ($urandom_range(0, 9) < 6);
            rst         = ($urandom_range(0, 499) != 0);
            for (int k = 0; k < NCH; k++) psum_in[k*PW +: PW] = PW'($urandom);
            cycle();
        end
        rst = 1'b1; idle_inputs(); out_ready = 1'b1; run(40);

        // Small wrapping build: four lanes, 12-bit accumulators
        tick(); tick(); s_rst = 1'b1;
        s_acc_clear = 1'b1; tick(); s_acc_clear = 1'b0;
        s_psum = {8'd4, 8'd3, 8'd2, 8'd1}; s_acc_en = 1'b1;
        repeat (4) tick();
        s_acc_en = 1'b0; s_out_ready = 1'b1; s_drain_start = 1'b1; tick(); s_drain_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("s_valid", longint'(s_out_valid), 1);
            check("s_ch", longint'(s_out_ch), i);
            check("s_data", longint'($signed(s_out_data)), 4 * (i + 1));
            tick();
        end
        check("s_done", longint'(s_drain_done), 1);
        check("s_valid_end", longint'(s_out_valid), 0);
        tick();
        check("s_done_once", longint'(s_drain_done), 0);
        check("s_busy_end", longint'(s_busy), 0);
        s_acc_clear = 1'b1; tick(); s_acc_clear = 1'b0;
        s_psum = {8'd0, 8'd0, 8'd0, 8'd127}; s_acc_en = 1'b1;
        repeat (17) tick();
        s_acc_en = 1'b0;
        check("s_wrap_ovf", longint'(s_overflow), 1);
        s_drain_start = 1'b1; tick(); s_drain_start = 1'b0;
        check("s_wrap_w0", longint'($signed(s_out_data)), -1937);
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
